// File: rtl/pipelined_instruction_decoder.sv
// Pipelined instruction decoder: splits an instruction word into control
// strobes, a one-hot register select and a zero-extended immediate/DM address.
// A single registered output stage with valid/ready flow control, plus a
// two-state FSM that joins LD_IMX with its payload word into one wide immediate.
module pipelined_instruction_decoder #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 4,
  parameter int INS_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INS_W-1:0]      ins_i,
  input  logic                  ins_valid_i,
  output logic                  ins_ready_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [NUM_REGS-1:0]   reg_addr_o,
  output logic [2*DATA_W-1:0]   data_o,
  output logic [1:0]            sel_o,
  output logic [2:0]            alu_code_o,
  output logic                  reg_ce_o,
  output logic                  dm_ce_o,
  output logic                  carry_ce_o,
  output logic                  accu_ce_o,
  output logic                  ill_o
);

  localparam int RN_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  // Reject parameter sets whose fields do not fit or whose register count is unusable
  generate
    if ((INS_W < 5 + RN_W + DATA_W) || (NUM_REGS < 2) ||
        ((NUM_REGS & (NUM_REGS - 1)) != 0)) begin : g_bad_params
      $error("pipelined_instruction_decoder: illegal DATA_W/NUM_REGS/INS_W combination");
    end
  endgenerate

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_EXT  = 1'b1;

  localparam logic [1:0] SEL_R   = 2'd0;
  localparam logic [1:0] SEL_DM  = 2'd1;
  localparam logic [1:0] SEL_IMD = 2'd2;

  localparam logic [2:0] ALU_LD  = 3'd6;
  localparam logic [2:0] ALU_DEF = 3'd7;

  localparam logic [4:0] OP_LD_IMX = 5'b11101;

  // Instruction fields
  logic [4:0]        opcode_s;
  logic [1:0]        section_s;
  logic [2:0]        rest_s;
  logic [RN_W-1:0]   rnum_s;
  logic [DATA_W-1:0] imm_s;
  logic              unused_ins_s;

  assign opcode_s  = ins_i[INS_W-1 -: 5];
  assign section_s = opcode_s[4:3];
  assign rest_s    = opcode_s[2:0];
  assign rnum_s    = ins_i[INS_W-6 -: RN_W];
  assign imm_s     = ins_i[DATA_W-1:0];
  // Bits between rnum and imm (when INS_W is wider than the fields) carry nothing
  assign unused_ins_s = ^ins_i;

  // State
  logic [0:0]          state_q, state_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  logic [RN_W-1:0]     ext_rnum_q, ext_rnum_d;
  logic                out_valid_q, out_valid_d;
  logic [NUM_REGS-1:0] reg_addr_q, reg_addr_d;
  logic [2*DATA_W-1:0] data_q, data_d;
  logic [1:0]          sel_q, sel_d;
  logic [2:0]          alu_code_q, alu_code_d;
  // Strobe vector order: {reg_ce, dm_ce, carry_ce, accu_ce, ill}
  logic [4:0]          strobe_q, strobe_d;

  // Decoded bundle (combinational)
  logic [NUM_REGS-1:0] dec_reg_addr_s;
  logic [2*DATA_W-1:0] dec_data_s;
  logic [1:0]          dec_sel_s;
  logic [2:0]          dec_alu_s;
  logic [4:0]          dec_strobe_s;
  logic [RN_W-1:0]     dec_rnum_s;

  logic ins_ready_s;
  logic accept_s;
  logic is_ldimx_s;
  logic load_s;

  // Decode the incoming word; in EXT the word is only payload for the pending LD_IMX
  always_comb begin
    dec_sel_s    = SEL_R;
    dec_alu_s    = ALU_DEF;
    dec_strobe_s = 5'b00000;
    dec_rnum_s   = rnum_s;
    dec_data_s   = {{DATA_W{1'b0}}, imm_s};
    if (state_q == ST_EXT) begin
      dec_sel_s     = SEL_IMD;
      dec_alu_s     = ALU_LD;
      dec_strobe_s  = 5'b00010;
      dec_rnum_s    = ext_rnum_q;
      dec_data_s    = {imm_s, lo_q};
    end else begin
      case (section_s)
        2'd0, 2'd1, 2'd2: begin
          dec_sel_s       = section_s;
          dec_alu_s       = (rest_s <= 3'd5) ? rest_s : ALU_DEF;
          dec_strobe_s[2] = (rest_s <= 3'd1);
          dec_strobe_s[1] = (rest_s <= 3'd5);
        end
        2'd3: begin
          case (rest_s)
            3'd0: begin dec_sel_s = SEL_R;   dec_alu_s = ALU_LD; dec_strobe_s = 5'b00010; end
            3'd1: begin dec_sel_s = SEL_DM;  dec_alu_s = ALU_LD; dec_strobe_s = 5'b00010; end
            3'd2: begin dec_sel_s = SEL_IMD; dec_alu_s = ALU_LD; dec_strobe_s = 5'b00010; end
            3'd3: begin dec_sel_s = SEL_R;   dec_alu_s = ALU_DEF; dec_strobe_s = 5'b10000; end
            3'd4: begin dec_sel_s = SEL_DM;  dec_alu_s = ALU_DEF; dec_strobe_s = 5'b01000; end
            3'd5: begin dec_sel_s = SEL_IMD; dec_alu_s = ALU_LD; dec_strobe_s = 5'b00010; end
            default: begin dec_sel_s = SEL_R; dec_alu_s = ALU_DEF; dec_strobe_s = 5'b00001; end
          endcase
        end
        default: begin
          dec_sel_s    = SEL_R;
          dec_alu_s    = ALU_DEF;
          dec_strobe_s = 5'b00000;
        end
      endcase
    end
    dec_reg_addr_s = NUM_REGS'(1'b1) << dec_rnum_s;
  end

  // Handshake: EXT always swallows the payload word since it has no output yet
  always_comb begin
    if (state_q == ST_EXT) begin
      ins_ready_s = 1'b1;
    end else begin
      ins_ready_s = !out_valid_q || out_ready_i;
    end
  end

  assign accept_s   = ins_valid_i && ins_ready_s;
  assign is_ldimx_s = (state_q == ST_IDLE) && (opcode_s == OP_LD_IMX);
  assign load_s     = accept_s && !is_ldimx_s;

  // FSM next state: LD_IMX parks its low half, the following word completes it
  always_comb begin
    state_d    = state_q;
    lo_d       = lo_q;
    ext_rnum_d = ext_rnum_q;
    if (accept_s) begin
      if (state_q == ST_EXT) begin
        state_d = ST_IDLE;
      end else if (is_ldimx_s) begin
        state_d    = ST_EXT;
        lo_d       = imm_s;
        ext_rnum_d = rnum_s;
      end else begin
        state_d = ST_IDLE;
      end
    end else begin
      state_d = state_q;
    end
  end

  // Output stage next state: load new bundle, retire on handshake, else hold
  always_comb begin
    out_valid_d = out_valid_q;
    reg_addr_d  = reg_addr_q;
    data_d      = data_q;
    sel_d       = sel_q;
    alu_code_d  = alu_code_q;
    strobe_d    = strobe_q;
    if (load_s) begin
      out_valid_d = 1'b1;
      reg_addr_d  = dec_reg_addr_s;
      data_d      = dec_data_s;
      sel_d       = dec_sel_s;
      alu_code_d  = dec_alu_s;
      strobe_d    = dec_strobe_s;
    end else if (out_valid_q && out_ready_i) begin
      // Strobes must not linger once the bundle has been consumed
      out_valid_d = 1'b0;
      strobe_d    = 5'b00000;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      lo_q        <= {DATA_W{1'b0}};
      ext_rnum_q  <= {RN_W{1'b0}};
      out_valid_q <= 1'b0;
      reg_addr_q  <= {NUM_REGS{1'b0}};
      data_q      <= {(2*DATA_W){1'b0}};
      sel_q       <= SEL_R;
      alu_code_q  <= ALU_DEF;
      strobe_q    <= 5'b00000;
    end else begin
      state_q     <= state_d;
      lo_q        <= lo_d;
      ext_rnum_q  <= ext_rnum_d;
      out_valid_q <= out_valid_d;
      reg_addr_q  <= reg_addr_d;
      data_q      <= data_d;
      sel_q       <= sel_d;
      alu_code_q  <= alu_code_d;
      strobe_q    <= strobe_d;
    end
  end

  assign ins_ready_o = ins_ready_s;
  assign out_valid_o = out_valid_q;
  assign reg_addr_o  = reg_addr_q;
  assign data_o      = data_q;
  assign sel_o       = sel_q;
  assign alu_code_o  = alu_code_q;
  assign reg_ce_o    = strobe_q[4];
  assign dm_ce_o     = strobe_q[3];
  assign carry_ce_o  = strobe_q[2];
  assign accu_ce_o   = strobe_q[1];
  assign ill_o       = strobe_q[0];

endmodule

// File: tb/tb_pipelined_instruction_decoder.sv
// Scoreboard bench for pipelined_instruction_decoder: directed scenarios plus
// randomized traffic against a rule-level reference model.
module tb_pipelined_instruction_decoder;

  logic        clk;
  logic        rst;
  logic [15:0] ins;
  logic        ins_valid, ins_ready, out_valid, out_ready;
  logic [3:0]  reg_addr;
  logic [15:0] data;
  logic [1:0]  sel;
  logic [2:0]  alu_code;
  logic        reg_ce, dm_ce, carry_ce, accu_ce, ill;

  // Second instance with 8 registers and 18-bit words
  logic [17:0] ins2;
  logic        ins2_valid, ins2_ready, out2_valid;
  logic [7:0]  reg_addr2;
  logic [15:0] data2;
  logic [1:0]  sel2;
  logic [2:0]  alu2;
  logic        reg_ce2, dm_ce2, carry_ce2, accu_ce2, ill2;

  int tests = 0;
  int fails = 0;

  logic [29:0] exp_q[$];
  bit          ext_pending;
  logic [7:0]  lo_m;
  logic [1:0]  ext_rn_m;
  logic [29:0] act;

  assign act = {reg_addr, data, sel, alu_code, reg_ce, dm_ce, carry_ce, accu_ce, ill};

  pipelined_instruction_decoder #(.DATA_W(8), .NUM_REGS(4), .INS_W(16)) dut (
    .clk(clk), .rst(rst), .ins_i(ins), .ins_valid_i(ins_valid), .ins_ready_o(ins_ready),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .reg_addr_o(reg_addr), .data_o(data),
    .sel_o(sel), .alu_code_o(alu_code), .reg_ce_o(reg_ce), .dm_ce_o(dm_ce),
    .carry_ce_o(carry_ce), .accu_ce_o(accu_ce), .ill_o(ill)
  );

  pipelined_instruction_decoder #(.DATA_W(8), .NUM_REGS(8), .INS_W(18)) dut8 (
    .clk(clk), .rst(rst), .ins_i(ins2), .ins_valid_i(ins2_valid), .ins_ready_o(ins2_ready),
    .out_valid_o(out2_valid), .out_ready_i(1'b1), .reg_addr_o(reg_addr2), .data_o(data2),
    .sel_o(sel2), .alu_code_o(alu2), .reg_ce_o(reg_ce2), .dm_ce_o(dm_ce2),
    .carry_ce_o(carry_ce2), .accu_ce_o(accu_ce2), .ill_o(ill2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected bundle {reg_addr, data, sel, alu, reg_ce, dm_ce, carry_ce, accu_ce, ill}
  function automatic logic [29:0] model_bundle(input logic [4:0] op, input logic [1:0] rn,
                                               input logic [15:0] d);
    logic [1:0] sec;
    logic [2:0] r;
    int         sel_tab[8] = '{0, 1, 2, 0, 1, 2, 0, 0};
    logic [1:0] s;
    logic [2:0] a;
    logic       rce, dce, cce, ace, il;
    sec = op[4:3];
    r   = op[2:0];
    rce = 1'b0; dce = 1'b0; cce = 1'b0; ace = 1'b0; il = 1'b0;
    if (sec != 2'd3) begin
      s   = sec;
      a   = (r <= 3'd5) ? r : 3'd7;
      cce = (r <= 3'd1);
      ace = (r <= 3'd5);
    end else begin
      s   = 2'(sel_tab[r]);
      ace = (r inside {3'd0, 3'd1, 3'd2, 3'd5});
      a   = ace ? 3'd6 : 3'd7;
      rce = (r == 3'd3);
      dce = (r == 3'd4);
      il  = (r >= 3'd6);
    end
    return {4'(1 << rn), d, s, a, rce, dce, cce, ace, il};
  endfunction

  function automatic logic [15:0] mk(input logic [4:0] op, input logic [1:0] rn,
                                     input logic [7:0] imm);
    return {op, rn, 1'b0, imm};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  // Drive one cycle at posedge+1, check ready against the model, record accepted words
  task automatic step(input logic v, input logic [15:0] w, input logic r);
    logic exp_ready;
    ins_valid = v;
    ins       = w;
    out_ready = r;
    #1;
    exp_ready = ext_pending || (exp_q.size() == 0) || r;
    check("ins_ready", {31'd0, ins_ready}, {31'd0, exp_ready});
    if (v && exp_ready) begin
      if (ext_pending) begin
        exp_q.push_back(model_bundle(5'b11101, ext_rn_m, {w[7:0], lo_m}));
        ext_pending = 1'b0;
      end else if (w[15:11] == 5'b11101) begin
        ext_pending = 1'b1;
        lo_m        = w[7:0];
        ext_rn_m    = w[10:9];
      end else begin
        exp_q.push_back(model_bundle(w[15:11], w[10:9], {8'h00, w[7:0]}));
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare whatever the DUT presents against the scoreboard head
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_bundle: got %h, expected no bundle", act);
        end else begin
          check("bundle", {2'b00, act}, {2'b00, exp_q[0]});
          if (out_ready) void'(exp_q.pop_front());
        end
      end else begin
        check("idle_strobes", {27'd0, reg_ce, dm_ce, carry_ce, accu_ce, ill}, 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; ins = 16'h0000; ins_valid = 1'b0; out_ready = 1'b0;
    ins2 = 18'h00000; ins2_valid = 1'b0;
    ext_pending = 1'b0; lo_m = 8'h00; ext_rn_m = 2'd0;
    #3;
    check("reset_valid", {31'd0, out_valid}, 32'd0);
    check("reset_bundle", {2'b00, act}, {2'b00, 4'h0, 16'h0000, 2'd0, 3'd7, 5'b00000});
    @(posedge clk);
    #1;
    rst = 1'b0;

    // ST_R r2
    step(1'b1, mk(5'b11011, 2'd2, 8'h3C), 1'b1);
    step(1'b0, 16'h0000, 1'b1);
    // LD_IMD A5 held three cycles, then a new ADD accepted on the same handshake
    step(1'b1, mk(5'b11010, 2'd1, 8'hA5), 1'b0);
    step(1'b1, mk(5'b00000, 2'd3, 8'h01), 1'b0);
    step(1'b1, mk(5'b00000, 2'd3, 8'h01), 1'b0);
    step(1'b1, mk(5'b00000, 2'd3, 8'h01), 1'b0);
    step(1'b1, mk(5'b00000, 2'd3, 8'h01), 1'b1);
    step(1'b0, 16'h0000, 1'b1);
    // LD_IMX lo=34, payload 12
    step(1'b1, mk(5'b11101, 2'd3, 8'h34), 1'b1);
    step(1'b1, mk(5'b00000, 2'd0, 8'h12), 1'b1);
    step(1'b0, 16'h0000, 1'b1);
    // ADD, SUB, rest 6 back to back
    step(1'b1, mk(5'b00000, 2'd0, 8'h11), 1'b1);
    step(1'b1, mk(5'b00001, 2'd1, 8'h22), 1'b1);
    step(1'b1, mk(5'b00110, 2'd2, 8'h33), 1'b1);
    step(1'b0, 16'h0000, 1'b1);
    // Illegal opcode
    step(1'b1, mk(5'b11110, 2'd1, 8'h44), 1'b1);
    step(1'b0, 16'h0000, 1'b1);
    // Reset while in EXT discards the pending LD_IMX
    step(1'b1, mk(5'b11101, 2'd1, 8'h77), 1'b1);
    ins_valid = 1'b0;
    rst = 1'b1;
    ext_pending = 1'b0;
    exp_q.delete();
    #1;
    check("rst_ext_valid", {31'd0, out_valid}, 32'd0);
    check("rst_ext_alu", {29'd0, alu_code}, 32'd7);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    step(1'b1, mk(5'b11010, 2'd2, 8'h5A), 1'b1);
    step(1'b0, 16'h0000, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [4:0] op;
      op = ($urandom_range(0, 3) == 0) ? 5'b11101 : 5'($urandom_range(0, 31));
      step($urandom_range(0, 3) != 0, mk(op, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255))),
           $urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 16'h0000, 1'b1);
    check("drain_empty", exp_q.size(), 32'd0);

    // 8-register instance: rnum 3'b101
    ins2 = {5'b00000, 3'b101, 2'b00, 8'h11};
    ins2_valid = 1'b1;
    @(posedge clk);
    #1;
    ins2_valid = 1'b0;
    check("nr8_valid", {31'd0, out2_valid}, 32'd1);
    check("nr8_reg_addr", {24'd0, reg_addr2}, {24'd0, 8'b0010_0000});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipelined_instruction_decoder.md
PIPELINED_INSTRUCTION_DECODER -- requirements
Module: pipelined_instruction_decoder

Interface
REQ-001 Parameters: DATA_W, default 8, immediate/DM-address field width; NUM_REGS, default 4, register count (power of 2, >=2); INS_W, default 16, instruction width.
REQ-002 Derived: RN_W = clog2(NUM_REGS); legality requires INS_W >= 5+RN_W+DATA_W, else elaboration error.
REQ-003 Instruction fields: opcode = ins[INS_W-1:INS_W-5]; section = opcode[4:3]; rest = opcode[2:0]; rnum = ins[INS_W-6:INS_W-5-RN_W]; imm = ins[DATA_W-1:0].
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 ins  in  INS_W  instruction word from program memory.
REQ-007 ins_valid  in  1  ins holds a valid word.
REQ-008 ins_ready  out  1  decoder accepts ins this cycle.
REQ-009 out_valid  out  1  decoded bundle valid.
REQ-010 out_ready  in  1  consumer accepts bundle.
REQ-011 reg_addr  out  NUM_REGS  one-hot register select.
REQ-012 data  out  2*DATA_W  immediate / DM address, zero-extended.
REQ-013 sel  out  2;  alu_code  out  3;  reg_ce, dm_ce, carry_ce, accu_ce, ill  out  1 each.

Function
REQ-014 Encodings: sel R=0, DM=1, IMD=2; section 3 = REST; alu_code ADD=0, SUB=1, ops 0..5 valid (NOT=5), LD=6, DEF=7.
REQ-015 Sections 0-2: sel=section; alu_code=rest if rest<=5 else 7; carry_ce=(rest<=1); accu_ce=(rest<=5).
REQ-016 Section 3 by rest: 0 LD_R sel=0; 1 LD_DM sel=1; 2 LD_IMD sel=2; 3 ST_R sel=0,reg_ce=1; 4 ST_DM sel=1,dm_ce=1; 5 LD_IMX sel=2; 6,7 ill=1,sel=0.
REQ-017 Section 3: alu_code=6 and accu_ce=1 for rest 0,1,2,5; alu_code=7, accu_ce=0 otherwise; carry_ce=0.
REQ-018 reg_addr = one-hot(rnum); data = {DATA_W'0, imm} except LD_IMX.
REQ-019 One registered output stage: latency exactly 1 cycle from accepted word to out_valid.
REQ-020 ins_ready = !out_valid || out_ready (combinational); transfer on ins_valid && ins_ready.
REQ-021 Output bundle held stable while out_valid && !out_ready; out_valid drops after handshake unless new word loaded same cycle.
REQ-022 All strobes (reg_ce, dm_ce, carry_ce, accu_ce, ill) forced 0 whenever out_valid=0; each fires once per bundle.
REQ-023 FSM states IDLE, EXT. IDLE + accepted LD_IMX -> EXT, imm saved to lo register, no bundle produced.
REQ-024 EXT + accepted word (any opcode, treated as payload) -> IDLE, emits LD_IMX bundle with data={payload imm, lo}, rnum from first word.
REQ-025 In EXT ins_ready = 1 (no output produced), regardless of out_ready.
REQ-026 Simultaneous output handshake and new acceptance: new bundle replaces old, no bubble, no duplicate.
REQ-027 Illegal opcodes produce a bundle with ill=1, all other strobes 0; no FSM effect.

Reset
REQ-028 On rst: out_valid=0, all strobes 0, reg_addr=0, data=0, sel=0, alu_code=7, FSM=IDLE, lo=0, immediately and asynchronously.
REQ-029 rst asserted in EXT discards pending LD_IMX; first word after release decodes from IDLE.

Verification
REQ-030 NUM_REGS=4: ins=ST_R r2 (opcode 5'b11011) valid, out_ready=1 -> next cycle out_valid=1, reg_ce=1, reg_addr=4'b0100, sel=0, alu_code=7, accu_ce=0.
REQ-031 LD_IMD imm=8'hA5 with out_ready=0 for 3 cycles -> bundle held 3 cycles, ins_ready=0, accu_ce=1 only while out_valid=1, data=16'h00A5.
REQ-032 LD_IMX lo=8'h34 then payload imm=8'h12 -> one bundle only, data=16'h1234, alu_code=6, sel=2.
REQ-033 Back-to-back ADD, SUB, opcode 5'b00110, out_ready=1 -> three consecutive bundles: carry_ce 1,1,0; alu_code 0,1,6->7 (rest 6 maps to 7).
REQ-034 Opcode 5'b11110 -> ill=1, all other strobes 0; rst during EXT -> out_valid=0, next LD_IMD decodes normally.
REQ-035 NUM_REGS=8, INS_W=18: rnum=3'b101 -> reg_addr=8'b0010_0000.
